// File: rtl/lc3_mem_arbiter.sv
// Shares the single-port LC-3 main memory between instruction fetch and data
// access: fixed DM priority with a streak limit so a waiting fetch is never starved.
module lc3_mem_arbiter #(
  parameter int ADDR_DEPTH    = 512,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [16:0]   DEPTH      = 17'(ADDR_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t        state, state_nxt;
  owner_t        owner;
  logic [SW-1:0] streak;
  logic          err_q;
  logic          wr_q;

  logic          any_req;
  logic          grant_dm;
  logic [15:0]   sel_addr;
  logic          sel_err;

  assign any_req  = if_req || dm_req;
  // DM has priority unless a waiting fetch has already lost MAX_DM_STREAK times.
  assign grant_dm = dm_req && (!if_req || (streak != STREAK_MAX));
  assign sel_addr = grant_dm ? dm_addr : if_addr;
  assign sel_err  = ({1'b0, sel_addr} >= DEPTH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access-context and memory-interface registers; the memory itself has no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_IF;
      streak    <= '0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant_dm ? OWN_DM : OWN_IF;
            err_q     <= sel_err;
            wr_q      <= grant_dm && dm_we;
            mem_en    <= !sel_err;
            mem_we    <= grant_dm && dm_we && !sel_err;
            mem_addr  <= sel_addr;
            mem_wdata <= grant_dm ? dm_wdata : 16'h0000;
            if (grant_dm && if_req)
              streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
              streak <= '0;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so the combinational block
  // cannot infer a latch on any path.
  always_comb begin
    if_done  = 1'b0;
    if_err   = 1'b0;
    if_rdata = 16'h0000;
    dm_done  = 1'b0;
    dm_err   = 1'b0;
    dm_rdata = 16'h0000;
    if (state == DONE) begin
      if (owner == OWN_IF) begin
        if_done  = 1'b1;
        if_err   = err_q;
        if_rdata = err_q ? 16'h0000 : mem_rdata;
      end else begin
        dm_done  = 1'b1;
        dm_err   = err_q;
        dm_rdata = (err_q || wr_q) ? 16'h0000 : mem_rdata;
      end
    end
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
- Sequences and shares the single-port LC-3 main memory between two requesters: instruction fetch (IF, read-only) and data memory (DM, LDR/STR/LDI/STI, read/write).
- Drives the memory's mem_en/we/addr/write-data inputs.
- Memory has 1-cycle registered read latency; a write commits at the clock edge where mem_en and we are both high.
- Fixed priority DM > IF, with a starvation guard so fetch always makes progress.

Parameters:
- ADDR_DEPTH, 512, number of implemented words; addresses >= ADDR_DEPTH are out of range.
- MAX_DM_STREAK, 4, max consecutive DM grants while if_req is pending before IF is forced.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  16  fetch address; stable while if_req high
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  16  fetched word; valid only while if_done=1
- if_err  out  1  out-of-range flag; valid only while if_done=1
- dm_req  in  1  data request; held high until dm_done
- dm_we  in  1  1=write, 0=read; stable while dm_req high
- dm_addr  in  16  data address; stable while dm_req high
- dm_wdata  in  16  write data; stable while dm_req high
- dm_done  out  1  one-cycle completion pulse
- dm_rdata  out  16  read word; valid only while dm_done=1
- dm_err  out  1  out-of-range flag; valid only while dm_done=1
- mem_en  out  1  memory enable, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  16  memory address, registered
- mem_wdata  out  16  memory write data, registered
- mem_rdata  in  16  memory read data, registered inside the memory

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, owner=IF, streak=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_done=dm_done=0, if_err=dm_err=0, *_rdata=0.
- FSM states: IDLE -> ISSUE -> DONE -> IDLE. One access per 3 cycles max.
- IDLE:
  - No request: stay in IDLE; mem_en=0.
  - Any request: select owner, latch err=(addr >= ADDR_DEPTH), go to ISSUE.
  - Next-cycle register values: mem_en=!err, mem_we=(owner==DM & dm_we & !err), mem_addr=addr, mem_wdata=dm_wdata (DM) else 0.
- Arbitration (evaluated in IDLE only):
  - Only one requester: it wins.
  - Both requesting: DM wins unless streak==MAX_DM_STREAK, in which case IF wins.
  - streak: +1 on each DM grant while if_req=1; cleared on any IF grant or on a DM grant with if_req=0; saturates at MAX_DM_STREAK.
  - Counter width is clog2(MAX_DM_STREAK+1).
- ISSUE:
  - mem_en/mem_we/mem_addr/mem_wdata hold the values latched in IDLE; the memory samples them at the end of this cycle.
  - Unconditionally go to DONE.
- DONE (the cycle after ISSUE):
  - Owner's *_done=1; all mem_* outputs return to 0.
  - Owner's *_rdata = err ? 0 : mem_rdata (combinational passthrough). Writes report rdata=0.
  - Owner's *_err = latched err. The non-owner's outputs stay 0.
  - Go to IDLE. Requests are not sampled in DONE: a req still high here is evaluated in the following IDLE cycle.
- Latency: request seen in IDLE at cycle N -> mem_en=1 in N+1 -> done in N+2.
- Out-of-range access: no memory cycle (mem_en stays 0); done still at N+2 with err=1, rdata=0.
- Request dropped early (req falls in ISSUE or DONE): the access still completes and done still pulses. Dropping req early is a requester protocol violation.
- Reset mid-operation:
  - rst during ISSUE: a write presented that cycle still commits at the edge, because the memory has no reset. No done is issued; all state returns to reset values.
  - rst during DONE: the done pulse is still visible in that cycle (outputs are state-driven), then everything is cleared.
- dm_we ignored when IF is owner; IF never writes.

Test Plan:
- Single IF read: preload mem[0x0010]=0x1234; if_req=1, if_addr=0x0010 -> mem_en=1/we=0/addr=0x0010 in cycle 1, if_done=1 with if_rdata=0x1234 in cycle 2, if_err=0.
- DM write then read: dm_we=1, dm_addr=0x01F0, dm_wdata=0xBEEF -> mem_we=1 in ISSUE, dm_done at +2. Then a dm read of 0x01F0 -> dm_rdata=0xBEEF.
- Simultaneous requests: both held high continuously -> grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF... (MAX_DM_STREAK=4); each done spaced 3 cycles apart.
- Out-of-range: dm_addr=0x0200 (ADDR_DEPTH=512), dm_we=1 -> mem_en stays 0; memory contents unchanged; dm_done=1, dm_err=1, dm_rdata=0 at +2.
- Reset in ISSUE: DM write to 0x0005=0xAAAA, rst=1 during ISSUE -> no dm_done, all outputs 0 next cycle, mem[0x0005]=0xAAAA, streak=0; a subsequent IF request completes normally.
- Held req: if_req left high across if_done -> next access is granted in the following IDLE cycle; issue again at +1, done at +2 relative to that IDLE.
